// File: rtl/mem_initiator.sv
// Single-master request/acknowledge bus initiator for the KV10 execute unit.
// Optional ack timeout enabled by defining MEM_TIMEOUT_EN.
module mem_initiator #(
    parameter int ADDR_W  = 18,
    parameter int WORD_W  = 36,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic              req_user,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rpw_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_write_data,
    output logic              mem_user,
    input  logic [WORD_W-1:0] mem_read_data,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, GAP, RPW_HOLD} state_t;

    state_t state;
    logic   rpw_rd;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            rpw_hold       <= 1'b0;
            mem_addr       <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_write_data <= '0;
            mem_user       <= 1'b0;
            rpw_rd         <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        if (req_op == 2'b11) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            mem_addr       <= req_addr;
                            mem_write_data <= req_wdata;
                            mem_user       <= req_user;
                            req_ready      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                            wait_cnt       <= '0;
`endif
                            if (req_op == 2'b01) begin
                                mem_write <= 1'b1;
                                rpw_rd    <= 1'b0;
                                state     <= WR_WAIT;
                            end else begin
                                mem_read <= 1'b1;
                                rpw_rd   <= (req_op == 2'b10);
                                state    <= RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (mem_ack) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= (state == RD_WAIT) ? mem_read_data : '0;
                        if (state == RD_WAIT && rpw_rd) begin
                            // Bus address/user stay latched for the write phase.
                            state     <= RPW_HOLD;
                            rpw_hold  <= 1'b1;
                            req_ready <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                GAP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                RPW_HOLD: begin
                    if (req_valid) begin
                        if (req_op == 2'b01) begin
                            mem_write_data <= req_wdata;
                            mem_write      <= 1'b1;
                            rpw_hold       <= 1'b0;
                            rpw_rd         <= 1'b0;
                            req_ready      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                            wait_cnt       <= '0;
`endif
                            state          <= WR_WAIT;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed + randomized bench for mem_initiator with a behavioural responder
// and a reference memory/latency model; covers MEM_TIMEOUT_EN when defined.
`timescale 1ns/1ps
module tb_mem_initiator;

    localparam int ADDR_W     = 18;
    localparam int WORD_W     = 36;
    localparam int TB_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = 2'b00;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [WORD_W-1:0] req_wdata = '0;
    logic              req_user = 1'b0;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rpw_hold;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] mem_write_data;
    logic              mem_user;
    logic [WORD_W-1:0] mem_read_data = '0;
    logic              mem_ack;

    always #5 clk = ~clk;

    mem_initiator #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_user(req_user),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rpw_hold(rpw_hold), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_write_data(mem_write_data), .mem_user(mem_user),
        .mem_read_data(mem_read_data), .mem_ack(mem_ack)
    );

    // Responder: acks after wait_states cycles and keeps acking while the request is held.
    int unsigned wait_states = 0;
    bit          ack_en = 1'b1;
    logic        stray = 1'b0;
    logic        ack_r = 1'b0;
    int unsigned rcnt = 0;
    logic [WORD_W-1:0] resp_mem [logic [ADDR_W:0]];
    logic [WORD_W-1:0] ref_mem  [logic [ADDR_W:0]];

    assign mem_ack = ack_r | stray;

    always @(posedge clk) begin
        logic [ADDR_W:0] key;
        key = {mem_user, mem_addr};
        if ((mem_read || mem_write) && ack_en) begin
            if (rcnt >= wait_states) begin
                ack_r <= 1'b1;
                if (mem_write) resp_mem[key] = mem_write_data;
                else mem_read_data <= resp_mem.exists(key) ? resp_mem[key] : '0;
            end else begin
                rcnt  <= rcnt + 1;
                ack_r <= 1'b0;
            end
        end else begin
            rcnt  <= 0;
            ack_r <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_count = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rsp_valid) rsp_count++;
        check("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);
    endtask

    function automatic logic [WORD_W-1:0] ref_read(input logic u, input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] k;
        k = {u, a};
        return ref_mem.exists(k) ? ref_mem[k] : '0;
    endfunction

    task automatic preload(input logic u, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        resp_mem[{u, a}] = d;
        ref_mem[{u, a}]  = d;
    endtask

    // Issues one request; lat = edges from the accepting edge to the visible rsp_valid.
    task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                         input logic [WORD_W-1:0] d, input logic u,
                         input logic [ADDR_W-1:0] exp_a, input logic exp_u,
                         output int lat, output logic [WORD_W-1:0] rd, output logic er);
        int n;
        logic [1:0] exp_rw;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_before_issue", 64'(req_ready), 64'd1);
        exp_rw = (op == 2'b01) ? 2'b01 : 2'b10;
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d; req_user = u;
        tick();
        req_valid = 1'b0;
        req_addr = $urandom_range(262143, 0);
        req_user = ~u;
        lat = 0;
        while (!rsp_valid && lat < 600) begin
            check("bus_rw_held", 64'({mem_read, mem_write}), 64'(exp_rw));
            check("bus_addr_held", 64'(mem_addr), 64'(exp_a));
            check("bus_user_held", 64'(mem_user), 64'(exp_u));
            if (op == 2'b01) check("bus_wdata_held", 64'(mem_write_data), 64'(d));
            tick();
            lat++;
        end
        check("rsp_arrived", 64'(rsp_valid), 64'd1);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    initial begin
        int lat;
        logic [WORD_W-1:0] rd;
        logic er;
        int c0;

        // Reset
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mem_rw", 64'({mem_read, mem_write}), 64'd0);
        check("rst_rpw_hold", 64'(rpw_hold), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);

        // Zero-wait read, with re-ack during GAP
        preload(1'b0, 18'o1000, 36'o123456701234);
        c0 = rsp_count;
        issue(2'b00, 18'o1000, '0, 1'b0, 18'o1000, 1'b0, lat, rd, er);
        check("rd0_latency", 64'(lat), 64'd2);
        check("rd0_data", 64'(rd), 64'(36'o123456701234));
        check("rd0_err", 64'(er), 64'd0);
        check("rd0_gap_bus_idle", 64'({mem_read, mem_write}), 64'd0);
        check("rd0_gap_not_ready", 64'(req_ready), 64'd0);
        tick();
        check("rd0_ready_after_gap", 64'(req_ready), 64'd1);
        check("rd0_single_rsp", 64'(rsp_count - c0), 64'd1);

        // Write user-space then read back
        issue(2'b01, 18'o2000, 36'o777777777777, 1'b1, 18'o2000, 1'b1, lat, rd, er);
        ref_mem[{1'b1, 18'o2000}] = 36'o777777777777;
        check("wr_latency", 64'(lat), 64'd2);
        check("wr_rdata_zero", 64'(rd), 64'd0);
        check("wr_err", 64'(er), 64'd0);
        issue(2'b00, 18'o2000, '0, 1'b1, 18'o2000, 1'b1, lat, rd, er);
        check("wr_readback", 64'(rd), 64'(ref_read(1'b1, 18'o2000)));

        // Wait-state responder, back-to-back reads
        preload(1'b0, 18'o10, 36'o111);
        preload(1'b0, 18'o11, 36'o222);
        wait_states = 3;
        issue(2'b00, 18'o10, '0, 1'b0, 18'o10, 1'b0, lat, rd, er);
        check("ws_rd10_latency", 64'(lat), 64'd5);
        check("ws_rd10_data", 64'(rd), 64'(36'o111));
        issue(2'b00, 18'o11, '0, 1'b0, 18'o11, 1'b0, lat, rd, er);
        check("ws_rd11_latency", 64'(lat), 64'd5);
        check("ws_rd11_data", 64'(rd), 64'(36'o222));

        // Randomized reads/writes against the reference memory
        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            logic [ADDR_W-1:0] a;
            logic u;
            logic [WORD_W-1:0] d;
            wait_states = $urandom_range(3, 0);
            op = ($urandom_range(1, 0) == 1) ? 2'b01 : 2'b00;
            a  = 18'o100 + 18'($urandom_range(3, 0));
            u  = 1'($urandom_range(1, 0));
            d  = {4'($urandom), 32'($urandom)};
            issue(op, a, d, u, a, u, lat, rd, er);
            check("rnd_latency", 64'(lat), 64'(2 + wait_states));
            check("rnd_err", 64'(er), 64'd0);
            if (op == 2'b01) begin
                check("rnd_wr_rdata", 64'(rd), 64'd0);
                ref_mem[{u, a}] = d;
            end else begin
                check("rnd_rd_data", 64'(rd), 64'(ref_read(u, a)));
            end
        end
        wait_states = 0;

        // Read-pause-write
        preload(1'b0, 18'o3000, 36'd5);
        issue(2'b10, 18'o3000, '0, 1'b0, 18'o3000, 1'b0, lat, rd, er);
        check("rpw_rd_latency", 64'(lat), 64'd2);
        check("rpw_rd_data", 64'(rd), 64'd5);
        check("rpw_rd_err", 64'(er), 64'd0);
        check("rpw_hold_set", 64'(rpw_hold), 64'd1);
        check("rpw_ready", 64'(req_ready), 64'd1);
        issue(2'b00, 18'o4000, '0, 1'b0, 18'o0, 1'b0, lat, rd, er);
        check("rpw_bad_op_latency", 64'(lat), 64'd0);
        check("rpw_bad_op_err", 64'(er), 64'd1);
        check("rpw_still_held", 64'(rpw_hold), 64'd1);
        check("rpw_bus_idle", 64'({mem_read, mem_write}), 64'd0);
        issue(2'b01, 18'o7777, 36'd6, 1'b1, 18'o3000, 1'b0, lat, rd, er);
        ref_mem[{1'b0, 18'o3000}] = 36'd6;
        check("rpw_wr_latency", 64'(lat), 64'd2);
        check("rpw_wr_err", 64'(er), 64'd0);
        check("rpw_hold_clear", 64'(rpw_hold), 64'd0);
        issue(2'b00, 18'o3000, '0, 1'b0, 18'o3000, 1'b0, lat, rd, er);
        check("rpw_readback", 64'(rd), 64'(ref_read(1'b0, 18'o3000)));
        issue(2'b00, 18'o7777, '0, 1'b1, 18'o7777, 1'b1, lat, rd, er);
        check("rpw_req_addr_ignored", 64'(rd), 64'(ref_read(1'b1, 18'o7777)));

        // Reserved op in IDLE
        issue(2'b11, 18'o5, '0, 1'b0, 18'o0, 1'b0, lat, rd, er);
        check("rsvd_latency", 64'(lat), 64'd0);
        check("rsvd_err", 64'(er), 64'd1);
        check("rsvd_ready", 64'(req_ready), 64'd1);
        check("rsvd_bus_idle", 64'({mem_read, mem_write}), 64'd0);

        // Reset during RD_WAIT, then stray acks
        wait_states = 5;
        while (!req_ready) tick();
        req_valid = 1'b1; req_op = 2'b00; req_addr = 18'o10; req_user = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        check("rstmid_reading", 64'(mem_read), 64'd1);
        c0 = rsp_count;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rstmid_read_dropped", 64'(mem_read), 64'd0);
        check("rstmid_ready", 64'(req_ready), 64'd1);
        check("rstmid_no_rsp", 64'(rsp_valid), 64'd0);
        stray = 1'b1;
        tick(); tick();
        stray = 1'b0;
        check("stray_ack_no_rsp", 64'(rsp_count - c0), 64'd0);
        check("stray_ack_bus_idle", 64'({mem_read, mem_write}), 64'd0);
        check("stray_ack_ready", 64'(req_ready), 64'd1);

        // Reset and ack on the same edge
        wait_states = 0;
        req_valid = 1'b1; req_op = 2'b00; req_addr = 18'o1000; req_user = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        c0 = rsp_count;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst_ack_no_rsp", 64'(rsp_valid), 64'd0);
        check("rst_ack_bus_idle", 64'(mem_read), 64'd0);
        tick();
        check("rst_ack_late_ignored", 64'(rsp_count - c0), 64'd0);
        check("rst_ack_ready", 64'(req_ready), 64'd1);

`ifdef MEM_TIMEOUT_EN
        // Responder silent: abort after TB_TIMEOUT cycles
        ack_en = 1'b0;
        issue(2'b00, 18'o1000, '0, 1'b0, 18'o1000, 1'b0, lat, rd, er);
        check("to_latency", 64'(lat), 64'(TB_TIMEOUT));
        check("to_err", 64'(er), 64'd1);
        check("to_rdata", 64'(rd), 64'd0);
        check("to_bus_idle", 64'({mem_read, mem_write}), 64'd0);
        check("to_gap_not_ready", 64'(req_ready), 64'd0);
        tick();
        check("to_ready_after_gap", 64'(req_ready), 64'd1);
        ack_en = 1'b1;
        issue(2'b00, 18'o1000, '0, 1'b0, 18'o1000, 1'b0, lat, rd, er);
        check("to_recover_data", 64'(rd), 64'(ref_read(1'b0, 18'o1000)));
        check("to_recover_err", 64'(er), 64'd0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- CPU-side master for the memory request/acknowledge bus. Accepts one read, write or read-pause-write request at a time from the execution unit.
- Drives mem_read / mem_write with held address, data and user-select until mem_ack returns, then hands the result back on a one-cycle response strobe.
- Sits between the KV10 instruction/execute sequencer and the memory responder; it is the only master on that bus.

Parameters:
- ADDR_W, 18, memory address width (matches `ADDR).
- WORD_W, 36, data word width (matches `WORD).
- TIMEOUT, 255, cycles to wait for mem_ack before aborting (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block can accept a request this cycle.
- req_op  in  2  00 read, 01 write, 10 read-pause-write (RPW), 11 reserved.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  WORD_W  write data (write op, and the RPW write phase).
- req_user  in  1  user (1) or exec (0) space.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  WORD_W  read data (read and RPW read phase), 0 for writes.
- rsp_err  out  1  valid with rsp_valid; 1 = timeout or reserved op.
- rpw_hold  out  1  high while an RPW awaits its write phase.
- mem_addr  out  ADDR_W  bus address.
- mem_read  out  1  bus read request.
- mem_write  out  1  bus write request.
- mem_write_data  out  WORD_W  bus write data.
- mem_user  out  1  bus space select.
- mem_read_data  in  WORD_W  read data, valid when mem_ack=1.
- mem_ack  in  1  responder acknowledge.

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; req_ready=1; all other outputs 0; timeout counter 0. Reset mid-transaction drops mem_read/mem_write the next cycle with no rsp_valid. Any later stray ack is ignored in IDLE.
- All outputs are registered. mem_read and mem_write are never both 1.
- States: IDLE, RD_WAIT, WR_WAIT, GAP, RPW_HOLD.
- IDLE, on req_valid & req_ready:
  - Latch addr, wdata, user onto the mem_* outputs.
  - op 00 or 10: mem_read=1, go to RD_WAIT. op 01: mem_write=1, go to WR_WAIT.
  - op 11: no bus cycle; rsp_valid=1, rsp_err=1 next cycle; stay IDLE.
  - req_ready=0 from the cycle after acceptance.
- RD_WAIT / WR_WAIT:
  - Hold mem_* stable until mem_ack is sampled 1.
  - On that edge: deassert the request, set rsp_valid=1 and rsp_err=0. For reads, rsp_rdata is the mem_read_data sampled at that edge; for writes it is 0.
  - Next state is GAP, except an RPW read, which goes to RPW_HOLD.
- GAP: exactly one cycle with mem_read=mem_write=0. mem_ack is ignored; the responder can re-ack a request held across its ack edge. Then IDLE with req_ready=1.
- RPW_HOLD:
  - rpw_hold=1, req_ready=1, mem_addr and mem_user held.
  - Only op 01 is accepted. Its req_addr and req_user are ignored and the held values are used; mem_write=1, go to WR_WAIT.
  - Any other op: rsp_valid=1, rsp_err=1, stay in RPW_HOLD.
  - A stray ack in the first cycle of RPW_HOLD is ignored.
- rsp_valid is a single-cycle pulse; rsp_rdata and rsp_err hold until the next response.
- Latency with a zero-wait responder, accept at edge E0:
  - Request visible after E0; responder acks after E1; ack sampled at E2 gives rsp_valid after E2.
  - GAP covers E2–E3; req_ready=1 after E3.
  - Read turnaround is 4 cycles accept-to-accept. Each responder wait state adds 1.
- Simultaneous events: mem_ack and reset_n=0 on the same edge means reset wins and no response is issued.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: an internal counter clears when RD_WAIT/WR_WAIT is entered and increments each cycle without ack. When it reaches TIMEOUT with no ack, the request is deasserted, rsp_valid=1, rsp_err=1, rsp_rdata=0, and the state goes to GAP. A timed-out RPW read does not enter RPW_HOLD.
- Not defined: no counter; the block waits for mem_ack indefinitely, rsp_err is driven only for op 11 and illegal RPW_HOLD ops, and the TIMEOUT parameter is unused.

Test Plan:
- Zero-wait responder, memory preloaded with 0o123456701234 at 0o1000: read 0o1000 -> rsp_valid 3 cycles after accept, rsp_rdata=0o123456701234, rsp_err=0, req_ready back 4 cycles after accept; second ack during GAP produces no extra rsp_valid.
- Write 0o777777777777 to 0o2000 (user=1), then read 0o2000 user=1 -> mem_write held with data stable until ack, read returns 0o777777777777, mem_read/mem_write never both high.
- Responder with 3 wait states, back-to-back reads of 0o10 and 0o11 -> mem_addr stable through each wait, each rsp_valid 3 cycles later than zero-wait, responses in order.
- RPW at 0o3000 (data 5): rsp_rdata=5, rpw_hold=1; issue op 00 -> rsp_err=1, still held; issue op 01 addr 0o7777 data 6 -> write lands at 0o3000, reading 0o3000 returns 6.
- MEM_TIMEOUT_EN, TIMEOUT=8, responder never acks -> rsp_valid with rsp_err=1 and rsp_rdata=0 exactly 8 cycles after the request appears, bus deasserted, next request accepted after GAP.
- Assert reset_n=0 for 1 cycle during RD_WAIT -> next cycle mem_read=0, state IDLE, req_ready=1, no rsp_valid; late ack ignored.
